rising2_en: RTL and testbench
=============================

Name: rising2_en

Overview:
- Rising-edge-to-enable converter: turns a level input, possibly asynchronous, into a single-clock-cycle enable pulse in the `clk` domain.
- Has an optional synchronizer chain of configurable depth in front of the edge detector.
- Used wherever a slow or external level (button, strobe, flag) must trigger one-cycle actions in synchronous logic.
- Also exports the synchronized level for downstream use.

Parameters:
- SYNC_STG, default 1: number of synchronizer flip-flops before edge detection.
  - Legal range 0..8.
  - 0 means `in` is already synchronous to `clk`; no synchronizer is inserted.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous reset, active-high.
- in  input  1  level input to be edge-detected.
- en  output  1  one-cycle enable pulse on each rising edge of (synchronized) `in`.
- out  output  1  synchronized/delayed copy of `in`; may be left unconnected.

Interface notes:
- One clock; reset is synchronous and active-high (`rst`, sampled on rising `clk`).

Behaviour:
- Internal shift register `d[0..SYNC_STG]`, all bits 1 wide.
  - Each rising `clk`: `d[0]` <= `in`, `d[i]` <= `d[i-1]`.
- Synchronized level `s`:
  - SYNC_STG = 0: `s` = `in` (combinational).
  - SYNC_STG >= 1: `s` = `d[SYNC_STG-1]`.
- `en` = `s` AND NOT `d[SYNC_STG]`, gated to 0 while `rst` = 1.
- `out` = `s`, gated to 0 while `rst` = 1.
- Reset: on a rising `clk` with `rst` = 1, all `d` bits load 0. While `rst` is high, `en` = 0 and `out` = 0.
- Latency, SYNC_STG = N >= 1:
  - `in` rises and is first sampled high at clock edge k.
  - `en` goes high after edge k+N-1 and stays high for exactly one clock period (until edge k+N).
  - `out` rises after edge k+N-1.
- Latency, SYNC_STG = 0:
  - `en` is high combinationally from the rise of `in` until the first rising `clk` that samples `in` high.
  - `in` must then be synchronous to `clk` for a clean one-cycle pulse.
- Falling edges of `in` produce no `en` activity. `out` falls with the same latency as its rise.
- Held-high input: exactly one `en` pulse per rising transition, regardless of how long `in` stays high.
- Short pulses: an `in` high level not sampled by any `clk` edge produces no pulse. A level held high for exactly one sampled edge produces exactly one pulse.
- Reset release with `in` already high: the registers start at 0, so the first high sample produces one `en` pulse (treated as a rising edge).
- `rst` asserted mid-pulse: `en` drops to 0 immediately and the chain clears. If `in` is still high after `rst` deasserts, a new pulse is generated per the previous rule.
- Toggling `in` every clock (SYNC_STG >= 1): `en` pulses every other cycle, never two consecutive cycles.
- No combinational path from `in` to `en` or `out` when SYNC_STG >= 1.

Test Plan:
- Clock period 10 ns, SYNC_STG = 1, `rst` high 2 cycles then low; `in` rises at 44 ns, falls at 100 ns.
  - Exactly one `en` pulse, 10 ns wide, starting at the first `clk` edge after 44 ns.
  - `out` high from that edge until the first edge after 100 ns.
  - No pulse on the fall.
- Same stimulus, SYNC_STG = 0 and SYNC_STG = 2.
  - SYNC_STG = 0: `en` high from 44 ns to the next `clk` edge.
  - SYNC_STG = 2: single 10 ns pulse starting one cycle later than the SYNC_STG = 1 case.
- `in` held high 20 cycles, then low 5, then high again (SYNC_STG = 1) -> exactly 2 `en` pulses, each 1 cycle wide.
- `in` toggled every clock for 10 cycles (SYNC_STG = 1) -> 5 pulses on alternating cycles; `en` never high 2 cycles in a row.
- `rst` asserted in the cycle `en` is high, with `in` held high -> `en` = 0 during reset; one new pulse after deassertion.
- `in` high during reset and left high after release -> exactly one `en` pulse, N-1 cycles after the first post-reset edge (SYNC_STG = N = 1, 2, 3).

Source files
------------

// File: rtl/rising2_en.sv
// rtl/rising2_en.sv - rising-edge-to-enable converter with optional synchronizer
module rising2_en #(
    parameter int SYNC_STG = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic en,
    output logic out
);

    // d[0..SYNC_STG-1] form the synchronizer; d[SYNC_STG] holds the previous
    // synchronized level used by the edge detector.
    logic [SYNC_STG:0] d;
    logic              s;

    generate
        if (SYNC_STG == 0) begin : g_no_sync
            // Input is already synchronous: only the edge-detect history register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    d <= '0;
                end else begin
                    d <= in;
                end
            end

            assign s = in;
        end else begin : g_sync
            // Shift the input through the synchronizer and into the history bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    d <= '0;
                end else begin
                    d <= {d[SYNC_STG-1:0], in};
                end
            end

            assign s = d[SYNC_STG-1];
        end
    endgenerate

    // Pulse on a low-to-high change of the synchronized level; both outputs are
    // forced low during reset so a held-high input re-triggers after release.
    always_comb begin
        en  = 1'b0;
        out = 1'b0;
        if (!rst) begin
            en  = s & ~d[SYNC_STG];
            out = s;
        end
    end

endmodule

// File: tb/tb_rising2_en.sv
// tb/tb_rising2_en.sv - directed self-checking bench for rising2_en
`timescale 1ns/1ps
module tb_rising2_en;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;
    logic en0, en1, en2, en3;
    logic out0, out1, out2, out3;

    int tests = 0;
    int fails = 0;

    int p0 = 0, p1 = 0, p2 = 0, p3 = 0;
    int b0, b1, b2, b3;
    int run1 = 0, max_run1 = 0;
    int run2 = 0, max_run2 = 0;

    rising2_en #(.SYNC_STG(0)) dut0 (.clk(clk), .rst(rst), .in(in), .en(en0), .out(out0));
    rising2_en #(.SYNC_STG(1)) dut1 (.clk(clk), .rst(rst), .in(in), .en(en1), .out(out1));
    rising2_en #(.SYNC_STG(2)) dut2 (.clk(clk), .rst(rst), .in(in), .en(en2), .out(out2));
    rising2_en #(.SYNC_STG(3)) dut3 (.clk(clk), .rst(rst), .in(in), .en(en3), .out(out3));

    always #5 clk = ~clk;

    always @(posedge en0) p0++;
    always @(posedge en1) p1++;
    always @(posedge en2) p2++;
    always @(posedge en3) p3++;

    always @(negedge clk) begin
        if (en1 === 1'b1) begin
            run1 = run1 + 1;
            if (run1 > max_run1) max_run1 = run1;
        end else begin
            run1 = 0;
        end
        if (en2 === 1'b1) begin
            run2 = run2 + 1;
            if (run2 > max_run2) max_run2 = run2;
        end else begin
            run2 = 0;
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        b0 = p0; b1 = p1; b2 = p2; b3 = p3;
    endtask

    initial begin
        // Basic stimulus: rst high for edges at 5 and 15, in 44..100 ns.
        #10;
        chk("rst_en0", en0, 1'b0);
        chk("rst_en1", en1, 1'b0);
        chk("rst_en2", en2, 1'b0);
        chk("rst_out1", out1, 1'b0);
        chk("rst_out3", out3, 1'b0);
        #10 rst = 1'b0;
        #10;
        chk("idle_en1", en1, 1'b0);
        chk("idle_out0", out0, 1'b0);
        #14 in = 1'b1;
        #0.5;
        chk("t44_en0", en0, 1'b1);
        chk("t44_out0", out0, 1'b1);
        chk("t44_en1", en1, 1'b0);
        chk("t44_out1", out1, 1'b0);
        #5.5;
        chk("t50_en0", en0, 1'b0);
        chk("t50_en1", en1, 1'b1);
        chk("t50_out1", out1, 1'b1);
        chk("t50_en2", en2, 1'b0);
        chk("t50_out2", out2, 1'b0);
        #10;
        chk("t60_en1", en1, 1'b0);
        chk("t60_en2", en2, 1'b1);
        chk("t60_en3", en3, 1'b0);
        chk("t60_out2", out2, 1'b1);
        #10;
        chk("t70_en2", en2, 1'b0);
        chk("t70_en3", en3, 1'b1);
        #10;
        chk("t80_en3", en3, 1'b0);
        chk("t80_out3", out3, 1'b1);
        chk("t80_out1", out1, 1'b1);
        #20 in = 1'b0;
        #0.5;
        chk("t100_out0", out0, 1'b0);
        chk("t100_out1", out1, 1'b1);
        chk("t100_en0", en0, 1'b0);
        #9.5;
        chk("t110_out1", out1, 1'b0);
        chk("t110_out2", out2, 1'b1);
        chk("t110_en1", en1, 1'b0);
        #10;
        chk("t120_out2", out2, 1'b0);
        chk("t120_out3", out3, 1'b1);
        chk("t120_en2", en2, 1'b0);
        #10;
        chk_int("basic_p0", p0, 1);
        chk_int("basic_p1", p1, 1);
        chk_int("basic_p2", p2, 1);
        chk_int("basic_p3", p3, 1);

        // Held high 20 cycles, low 5, high again.
        snap();
        in = 1'b1;
        for (int i = 0; i < 20; i++) step();
        in = 1'b0;
        for (int i = 0; i < 5; i++) step();
        in = 1'b1;
        for (int i = 0; i < 6; i++) step();
        in = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk_int("held_p0", p0 - b0, 2);
        chk_int("held_p1", p1 - b1, 2);
        chk_int("held_p2", p2 - b2, 2);
        chk_int("held_p3", p3 - b3, 2);

        // Toggle every clock for 10 cycles.
        snap();
        for (int i = 0; i < 10; i++) begin
            in = ~in;
            step();
        end
        in = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk_int("tog_p1", p1 - b1, 5);
        chk_int("tog_p2", p2 - b2, 5);
        chk_int("tog_p0", p0 - b0, 5);

        // Reset asserted while en is high, in held high.
        snap();
        in = 1'b1;
        step();
        chk("mid_en1_pre", en1, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_en1_rst", en1, 1'b0);
        chk("mid_out1_rst", out1, 1'b0);
        step();
        chk("mid_en1_rst2", en1, 1'b0);
        step();
        chk("mid_out2_rst3", out2, 1'b0);
        rst = 1'b0;
        step();
        chk("mid_en1_post", en1, 1'b1);
        step();
        chk("mid_en1_end", en1, 1'b0);
        chk_int("mid_p1", p1 - b1, 2);
        in = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // In high through reset and after release.
        rst = 1'b1;
        in  = 1'b1;
        step();
        step();
        snap();
        chk("rel_en0_rst", en0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rel_en0", en0, 1'b1);
        chk("rel_en1_pre", en1, 1'b0);
        step();
        chk("rel_c0_en1", en1, 1'b1);
        chk("rel_c0_en2", en2, 1'b0);
        chk("rel_c0_en3", en3, 1'b0);
        chk("rel_c0_en0", en0, 1'b0);
        step();
        chk("rel_c1_en1", en1, 1'b0);
        chk("rel_c1_en2", en2, 1'b1);
        chk("rel_c1_en3", en3, 1'b0);
        step();
        chk("rel_c2_en2", en2, 1'b0);
        chk("rel_c2_en3", en3, 1'b1);
        step();
        chk("rel_c3_en3", en3, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk_int("rel_p0", p0 - b0, 1);
        chk_int("rel_p1", p1 - b1, 1);
        chk_int("rel_p2", p2 - b2, 1);
        chk_int("rel_p3", p3 - b3, 1);

        chk_int("max_run1", max_run1, 1);
        chk_int("max_run2", max_run2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
